sr_latch: RTL and testbench

SR_LATCH -- requirements
Module: sr_latch

---
 rtl/sr_latch_if.sv | 35 +++
 rtl/sr_latch.sv | 131 +++++++++++++
 tb/tb_sr_latch.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/sr_latch_if.sv
// sr_latch_if -- bundle of the SR latch request and status signals.
//
// Signals:
//   S    set request, active-high
//   R    reset request, active-high
//   P    true latch output
//   Q    complementary latch output
//   inv  forbidden-combination indicator
//
// Modports:
//   master  drives the requests and observes the latch outputs
//   slave   receives the requests and drives the latch outputs
interface sr_latch_if;
    logic S;
    logic R;
    logic P;
    logic Q;
    logic inv;

    modport master (
        output S,
        output R,
        input  P,
        input  Q,
        input  inv
    );

    modport slave (
        input  S,
        input  R,
        output P,
        output Q,
        output inv
    );
endinterface : sr_latch_if

// File: rtl/sr_latch.sv
// sr_latch -- clocked SR latch with input synchronizers and a registered
// forbidden-condition flag.
//
// Parameters:
//   SYNC_STAGES  synchronizer flops per request input, legal range 0..4
//                (0 = raw inputs sampled directly by the state logic)
//   RESET_STATE  stored state after reset (0 = P low, 1 = P high)
//
// Ports (positional order clk, rst, S, R, P, Q, inv):
//   clk  in   sole clock, rising edge
//   rst  in   asynchronous, active-high reset
//   S    in   set request, asynchronous to clk
//   R    in   reset request, asynchronous to clk
//   P    out  registered stored state (0 while forbidden)
//   Q    out  registered complement of stored state (0 while forbidden)
//   inv  out  registered flag, high while S and R are both asserted
//
// The stored state and the visible outputs are separate registers: a
// forbidden (1,1) pair forces P/Q low without touching the stored state,
// so leaving to (0,0) restores the pre-forbidden value in one cycle.
module sr_latch #(
    parameter int SYNC_STAGES = 2,
    parameter bit RESET_STATE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic S,
    input  logic R,
    output logic P,
    output logic Q,
    output logic inv
);

    logic s_sync_s;
    logic r_sync_s;

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign s_sync_s = S;
            assign r_sync_s = R;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] s_chain_q;
            logic [SYNC_STAGES-1:0] r_chain_q;

            // Shift both request inputs through the synchronizer chains.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s_chain_q <= '0;
                    r_chain_q <= '0;
                end else begin
                    s_chain_q[0] <= S;
                    r_chain_q[0] <= R;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        s_chain_q[i] <= s_chain_q[i-1];
                        r_chain_q[i] <= r_chain_q[i-1];
                    end
                end
            end

            assign s_sync_s = s_chain_q[SYNC_STAGES-1];
            assign r_sync_s = r_chain_q[SYNC_STAGES-1];
        end
    endgenerate

    logic state_q;
    logic state_d;
    logic p_q;
    logic p_d;
    logic q_q;
    logic q_d;
    logic inv_q;
    logic inv_d;

    // Decode the synchronized request pair into next state and outputs.
    always_comb begin
        state_d = state_q;
        p_d     = state_q;
        q_d     = ~state_q;
        inv_d   = 1'b0;
        case ({s_sync_s, r_sync_s})
            2'b10: begin
                state_d = 1'b1;
                p_d     = 1'b1;
                q_d     = 1'b0;
            end
            2'b01: begin
                state_d = 1'b0;
                p_d     = 1'b0;
                q_d     = 1'b1;
            end
            2'b00: begin
                state_d = state_q;
                p_d     = state_q;
                q_d     = ~state_q;
            end
            2'b11: begin
                // Forbidden pair: keep stored state, drive NOR-latch outputs.
                state_d = state_q;
                p_d     = 1'b0;
                q_d     = 1'b0;
                inv_d   = 1'b1;
            end
            default: begin
                state_d = state_q;
                p_d     = state_q;
                q_d     = ~state_q;
                inv_d   = 1'b0;
            end
        endcase
    end

    // Stored state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_STATE;
            p_q     <= RESET_STATE;
            q_q     <= ~RESET_STATE;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            q_q     <= q_d;
            inv_q   <= inv_d;
        end
    end

    assign P   = p_q;
    assign Q   = q_q;
    assign inv = inv_q;

endmodule : sr_latch

// File: tb/tb_sr_latch.sv
// tb_sr_latch -- self-checking bench for sr_latch. Two instances share the
// same request inputs: dut0 with SYNC_STAGES=2/RESET_STATE=0 and dut1 with
// SYNC_STAGES=0/RESET_STATE=1. A reference model keeps the log of request
// values seen at each rising edge since reset and derives each instance's
// effective pair from that log delayed by its synchronizer depth.
module tb_sr_latch;

    logic clk;
    logic rst;

    sr_latch_if if0 ();
    sr_latch_if if1 ();

    sr_latch #(.SYNC_STAGES(2), .RESET_STATE(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .S   (if0.S),
        .R   (if0.R),
        .P   (if0.P),
        .Q   (if0.Q),
        .inv (if0.inv)
    );

    sr_latch #(.SYNC_STAGES(0), .RESET_STATE(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .S   (if1.S),
        .R   (if1.R),
        .P   (if1.P),
        .Q   (if1.Q),
        .inv (if1.inv)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int passes = 0;

    // Reference model state.
    bit ls[$];
    bit lr[$];
    int nst [2] = '{2, 0};
    bit rsv [2] = '{1'b0, 1'b1};
    bit mst [2];
    bit mp  [2];
    bit mq  [2];
    bit minv[2];

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s at t=%0t observed=%b expected=%b", tag, $time, obs, exp);
    endtask

    task automatic model_reset();
        ls.delete();
        lr.delete();
        for (int i = 0; i < 2; i++) begin
            mst[i]  = rsv[i];
            mp[i]   = rsv[i];
            mq[i]   = !rsv[i];
            minv[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input bit s, input bit r);
        int idx;
        bit es;
        bit er;
        ls.push_back(s);
        lr.push_back(r);
        for (int i = 0; i < 2; i++) begin
            idx = ls.size() - 1 - nst[i];
            es  = (idx >= 0) ? ls[idx] : 1'b0;
            er  = (idx >= 0) ? lr[idx] : 1'b0;
            if (es && er) begin
                mp[i] = 1'b0; mq[i] = 1'b0; minv[i] = 1'b1;
            end else begin
                if (es) mst[i] = 1'b1;
                if (er) mst[i] = 1'b0;
                mp[i] = mst[i]; mq[i] = !mst[i]; minv[i] = 1'b0;
            end
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, " dut0.P"},   if0.P,   mp[0]);
        chk({ph, " dut0.Q"},   if0.Q,   mq[0]);
        chk({ph, " dut0.inv"}, if0.inv, minv[0]);
        chk({ph, " dut1.P"},   if1.P,   mp[1]);
        chk({ph, " dut1.Q"},   if1.Q,   mq[1]);
        chk({ph, " dut1.inv"}, if1.inv, minv[1]);
    endtask

    // Starts just after a falling edge; holds (s,r) for n rising edges.
    task automatic cycles(input bit s, input bit r, input int n, input string ph);
        if0.S = s; if0.R = r;
        if1.S = s; if1.R = r;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge(s, r);
            #1;
            check_all(ph);
            @(negedge clk);
        end
    endtask

    // Starts at a falling edge; asynchronous reset pulse spanning one rising edge.
    task automatic do_reset(input string ph);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all({ph, " async"});
        @(posedge clk);
        #1;
        check_all({ph, " held"});
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit rs;
        bit rr;
        rst = 1'b0;
        if0.S = 1'b0; if0.R = 1'b0;
        if1.S = 1'b0; if1.R = 1'b0;

        // Reset before any clock edge.
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("rst_noclk");
        chk("rst_noclk const P0", if0.P, 1'b0);
        chk("rst_noclk const Q0", if0.Q, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        cycles(1'b0, 1'b1, 2, "reset_of_reset");
        cycles(1'b0, 1'b0, 4, "reset_of_reset idle");

        cycles(1'b1, 1'b0, 2, "set");
        chk("set latency dut0.P", if0.P, 1'b0);
        cycles(1'b0, 1'b0, 1, "set idle");
        chk("set third edge dut0.P", if0.P, 1'b1);
        cycles(1'b0, 1'b0, 4, "set hold");

        cycles(1'b0, 1'b1, 3, "clear");
        cycles(1'b0, 1'b0, 5, "clear hold");

        cycles(1'b1, 1'b0, 2, "reset_set");
        cycles(1'b0, 1'b0, 4, "reset_set hold");
        cycles(1'b1, 1'b1, 3, "forbid");
        chk("forbid dut0.inv", if0.inv, 1'b1);
        cycles(1'b0, 1'b0, 4, "forbid release");
        chk("forbid restore dut0.P", if0.P, 1'b1);

        cycles(1'b1, 1'b1, 4, "forbid2");
        cycles(1'b0, 1'b1, 3, "forbid to clear");
        cycles(1'b1, 1'b1, 4, "forbid3");
        cycles(1'b1, 1'b0, 3, "forbid to set");

        cycles(1'b1, 1'b1, 4, "forbid4");
        do_reset("rst_in_forbid");
        cycles(1'b0, 1'b0, 4, "after rst");

        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 31) == 0) begin
                do_reset("rand_rst");
            end else begin
                rs = 1'($urandom_range(0, 1));
                rr = 1'($urandom_range(0, 1));
                cycles(rs, rr, $urandom_range(1, 5), "rand");
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_sr_latch
